// File: rtl/tomasulo_pkg.sv
// rtl/tomasulo_pkg.sv - shared Tomasulo core widths, reserved tag and CDB bus type
package tomasulo_pkg;

    localparam int TAG_W       = 4;
    localparam int DATA_W      = 32;
    localparam int NUM_SRC_DEF = 4;

    // Tag 0 marks "operand ready" in the reservation stations, so it never names a producer
    localparam logic [TAG_W-1:0] TAG_NONE = '0;

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } cdb_bus_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter owning rr_ptr; grant is one-hot plus index
module rr_arbiter #(
    parameter int NUM_SRC = tomasulo_pkg::NUM_SRC_DEF,
    parameter int IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] req_i,
    input  logic               en_i,
    output logic [NUM_SRC-1:0] grant_o,
    output logic               grant_valid_o,
    output logic [IDX_W-1:0]   grant_idx_o
);

    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             found;

    // Scan starting at rr_ptr and wrap; the first requester seen wins
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            int j;
            j = int'(rr_ptr_q) + k;
            if (j >= NUM_SRC) j = j - NUM_SRC;
            if (en_i && !found && req_i[j]) begin
                found       = 1'b1;
                grant_o[j]  = 1'b1;
                grant_idx_o = IDX_W'(j);
            end
        end
        grant_valid_o = found;
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (found) begin
            rr_ptr_d = (grant_idx_o == IDX_W'(NUM_SRC - 1)) ? '0 : grant_idx_o + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) rr_ptr_q <= '0;
        else        rr_ptr_q <= rr_ptr_d;
    end

endmodule

// File: rtl/cdb_broadcaster.sv
// rtl/cdb_broadcaster.sv - CDB producer: round-robin pick, registered broadcast; CDB_TAG_CHECK_EN adds tag-0 trap
module cdb_broadcaster #(
    parameter int NUM_SRC = tomasulo_pkg::NUM_SRC_DEF,
    parameter int TAG_W   = tomasulo_pkg::TAG_W,
    parameter int DATA_W  = tomasulo_pkg::DATA_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_SRC-1:0]        req_valid_i,
    input  logic [NUM_SRC*TAG_W-1:0]  req_tag_i,
    input  logic [NUM_SRC*DATA_W-1:0] req_data_i,
    output logic [NUM_SRC-1:0]        req_ready_o,
    input  logic                      cdb_hold_i,
    output logic                      cdb_valid_o,
    output logic [TAG_W-1:0]          cdb_tag_o,
    output logic [DATA_W-1:0]         cdb_data_o,
    output logic                      busy_o
`ifdef CDB_TAG_CHECK_EN
    ,
    output logic                      err_tag_zero_o
`endif
);
    import tomasulo_pkg::*;

    localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic              gnt_valid;
    logic [IDX_W-1:0]  gnt_idx;
    logic [TAG_W-1:0]  win_tag;
    logic [DATA_W-1:0] win_data;
    logic              bcast;

    logic              cdb_valid_q, cdb_valid_d;
    logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
    logic [DATA_W-1:0] cdb_data_q, cdb_data_d;

    // Reset gates the enable so requesters never see ready while rst_n is low
    rr_arbiter #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (IDX_W)
    ) u_arb (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_i         (req_valid_i),
        .en_i          (rst_n & ~cdb_hold_i),
        .grant_o       (req_ready_o),
        .grant_valid_o (gnt_valid),
        .grant_idx_o   (gnt_idx)
    );

    assign win_tag  = req_tag_i[gnt_idx*TAG_W +: TAG_W];
    assign win_data = req_data_i[gnt_idx*DATA_W +: DATA_W];

`ifdef CDB_TAG_CHECK_EN
    assign bcast = gnt_valid && (win_tag != TAG_NONE);
`else
    assign bcast = gnt_valid;
`endif

    // Idle cycles drive zeros so snooping stations never match a stale tag
    always_comb begin
        cdb_valid_d = bcast;
        cdb_tag_d   = bcast ? win_tag  : '0;
        cdb_data_d  = bcast ? win_data : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
        end else begin
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_data_q  <= cdb_data_d;
        end
    end

`ifdef CDB_TAG_CHECK_EN
    logic err_q, err_d;

    assign err_d = err_q | (gnt_valid && (win_tag == TAG_NONE));

    always_ff @(posedge clk) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign err_tag_zero_o = err_q;
`endif

    assign cdb_valid_o = cdb_valid_q;
    assign cdb_tag_o   = cdb_tag_q;
    assign cdb_data_o  = cdb_data_q;
    assign busy_o      = (|req_valid_i) | cdb_valid_q;

endmodule

// File: tb/tb_cdb_broadcaster.sv
// tb/tb_cdb_broadcaster.sv - scoreboard bench for cdb_broadcaster with random and directed traffic
module tb_cdb_broadcaster;

    localparam int N  = 4;
    localparam int TW = 4;
    localparam int DW = 32;
`ifdef CDB_TAG_CHECK_EN
    localparam bit TCHK = 1'b1;
`else
    localparam bit TCHK = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req_valid;
    logic [N*TW-1:0]   req_tag;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_ready;
    logic              cdb_hold;
    logic              cdb_valid;
    logic [TW-1:0]     cdb_tag;
    logic [DW-1:0]     cdb_data;
    logic              busy;
    logic              err_dut;

    always #5 clk = ~clk;

    cdb_broadcaster #(.NUM_SRC(N), .TAG_W(TW), .DATA_W(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid),
        .req_tag_i   (req_tag),
        .req_data_i  (req_data),
        .req_ready_o (req_ready),
        .cdb_hold_i  (cdb_hold),
        .cdb_valid_o (cdb_valid),
        .cdb_tag_o   (cdb_tag),
        .cdb_data_o  (cdb_data),
        .busy_o      (busy)
`ifdef CDB_TAG_CHECK_EN
        ,
        .err_tag_zero_o (err_dut)
`endif
    );

`ifndef CDB_TAG_CHECK_EN
    assign err_dut = 1'b0;
`endif

    typedef struct {
        logic [N-1:0]  ready;
        logic          busy;
        logic          bv;
        logic [TW-1:0] bt;
        logic [DW-1:0] bd;
        logic          err;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    // Reference model state: per-source pending result, fairness pointer, next bus
    bit            sv[N];
    logic [TW-1:0] st[N];
    logic [DW-1:0] sd[N];
    int            waitc[N];
    int            ptr;
    logic          pv;
    logic [TW-1:0] pt;
    logic [DW-1:0] pd;
    logic          merr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_step(input bit rst, input bit hold);
        exp_t e;
        int   win;
        @(posedge clk);
        #1;
        rst_n    = rst;
        cdb_hold = hold;
        for (int i = 0; i < N; i++) begin
            req_valid[i]           = sv[i];
            req_tag[i*TW +: TW]    = st[i];
            req_data[i*DW +: DW]   = sd[i];
        end
        e.bv  = pv;
        e.bt  = pt;
        e.bd  = pd;
        e.err = merr;
        win = -1;
        if (rst && !hold) begin
            for (int k = 0; k < N; k++) begin
                if (win < 0 && sv[(ptr + k) % N]) win = (ptr + k) % N;
            end
        end
        e.ready = '0;
        if (win >= 0) e.ready[win] = 1'b1;
        e.busy = (|req_valid) | pv;
        sb.push_back(e);

        if (!rst) begin
            pv = 1'b0; pt = '0; pd = '0; ptr = 0; merr = 1'b0;
            for (int i = 0; i < N; i++) begin
                sv[i] = 1'b0; waitc[i] = 0;
            end
        end else begin
            pv = 1'b0; pt = '0; pd = '0;
            if (win >= 0) begin
                if (TCHK && st[win] == '0) begin
                    merr = 1'b1;
                end else begin
                    pv = 1'b1; pt = st[win]; pd = sd[win];
                end
                chk($sformatf("wait_bound_src%0d", win), 64'(waitc[win] <= N - 1), 64'd1);
                sv[win]    = 1'b0;
                waitc[win] = 0;
                ptr        = (win + 1) % N;
            end
            for (int i = 0; i < N; i++) begin
                if (sv[i] && !hold) waitc[i]++;
            end
        end
    endtask

    task automatic load(input int i, input logic [TW-1:0] t, input logic [DW-1:0] d);
        sv[i] = 1'b1;
        st[i] = t;
        sd[i] = d;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("req_ready", 64'(req_ready), 64'(e.ready));
                chk("busy",      64'(busy),      64'(e.busy));
                chk("cdb_valid", 64'(cdb_valid), 64'(e.bv));
                chk("cdb_tag",   64'(cdb_tag),   64'(e.bt));
                chk("cdb_data",  64'(cdb_data),  64'(e.bd));
`ifdef CDB_TAG_CHECK_EN
                chk("err_tag_zero", 64'(err_dut), 64'(e.err));
`endif
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        cdb_hold  = 1'b0;
        req_valid = '0;
        req_tag   = '0;
        req_data  = '0;
        ptr = 0; pv = 1'b0; pt = '0; pd = '0; merr = 1'b0;
        for (int i = 0; i < N; i++) begin
            sv[i] = 1'b0; st[i] = '0; sd[i] = '0; waitc[i] = 0;
        end
        repeat (2) @(posedge clk);

        // Reset state and single source
        do_step(0, 0);
        do_step(1, 0);
        load(1, 4'd3, 32'hDEAD_BEEF);
        repeat (3) do_step(1, 0);

        // All four continuously valid from reset: order 0,1,2,3,0
        do_step(0, 0);
        for (int c = 0; c < 6; c++) begin
            for (int i = 0; i < N; i++) if (!sv[i]) load(i, TW'(i + 1), $urandom);
            do_step(1, 0);
        end

        // Pointer at 3 with sources 3 and 0 pending: wrap
        do_step(0, 0);
        load(2, 4'd7, 32'h0000_0007);
        do_step(1, 0);
        load(3, 4'd9, 32'h0000_0009);
        load(0, 4'd10, 32'h0000_000A);
        repeat (3) do_step(1, 0);

        // Hold for three cycles with sources 0 and 2 waiting
        do_step(0, 0);
        load(0, 4'd11, 32'h1111_0000);
        load(2, 4'd12, 32'h2222_0000);
        repeat (3) do_step(1, 1);
        repeat (3) do_step(1, 0);

        // Reset right after a grant to tag 5
        load(1, 4'd5, 32'h5555_5555);
        do_step(1, 0);
        do_step(0, 0);
        load(0, 4'd1, 32'hA0A0_A0A0);
        load(3, 4'd2, 32'hB0B0_B0B0);
        repeat (3) do_step(1, 0);

`ifdef CDB_TAG_CHECK_EN
        load(1, 4'd0, 32'h0BAD_0000);
        load(2, 4'd6, 32'h0000_0666);
        repeat (5) do_step(1, 0);
        do_step(0, 0);
        do_step(1, 0);
`endif

        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!sv[i] && $urandom_range(0, 2) == 0) begin
                    load(i, TCHK ? TW'($urandom_range(0, 15)) : TW'($urandom_range(1, 15)), $urandom);
                end
            end
            do_step($urandom_range(0, 59) != 0, $urandom_range(0, 7) == 0);
        end
        repeat (2) do_step(1, 0);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
